// File: rtl/div_sched.sv
// Two-port round-robin front end for a shared iterative divider.
// One operation in flight; the response is held until consumed, and an operation is aborted after TIMEOUT busy cycles.
module div_sched #(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 64
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [1:0]        req_valid_i,
    output logic [1:0]        req_ready_o,
    input  logic [2*XLEN-1:0] req_a_i,
    input  logic [2*XLEN-1:0] req_b_i,
    input  logic [1:0]        req_is_q_i,
    input  logic              flush_i,
    output logic              resp_valid_o,
    input  logic              resp_ready_i,
    output logic [XLEN-1:0]   resp_data_o,
    output logic              resp_port_o,
    output logic              resp_err_o,
    output logic              div_start_o,
    output logic [XLEN-1:0]   div_a_o,
    output logic [XLEN-1:0]   div_b_o,
    output logic              div_is_q_o,
    input  logic [XLEN-1:0]   div_result_i,
    input  logic              div_done_i,
    output logic              busy_o
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;

    state_t            state_q, state_d;
    logic              rr_q, rr_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [XLEN-1:0]   a_q, a_d, b_q, b_d, data_q, data_d;
    logic              isq_q, isq_d, port_q, port_d, err_q, err_d;
    logic              grant_vld;
    logic              grant_port;

    // Both valid -> pointer decides; otherwise the single valid port wins.
    assign grant_vld  = (state_q == S_IDLE) && !flush_i && (|req_valid_i);
    assign grant_port = (&req_valid_i) ? rr_q : req_valid_i[1];

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        isq_d   = isq_q;
        port_d  = port_q;
        data_d  = data_q;
        err_d   = err_q;
        unique case (state_q)
            S_IDLE: begin
                if (grant_vld) begin
                    a_d     = grant_port ? req_a_i[2*XLEN-1:XLEN] : req_a_i[XLEN-1:0];
                    b_d     = grant_port ? req_b_i[2*XLEN-1:XLEN] : req_b_i[XLEN-1:0];
                    isq_d   = req_is_q_i[grant_port];
                    port_d  = grant_port;
                    rr_d    = ~grant_port;
                    cnt_d   = '0;
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                if (flush_i) begin
                    state_d = S_IDLE;
                end else if (div_done_i) begin
                    data_d  = div_result_i;
                    err_d   = 1'b0;
                    state_d = S_RESP;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    data_d  = '0;
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_RESP: begin
                if (flush_i || resp_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath registers are reset too so every output reads zero during reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            rr_q    <= 1'b0;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            isq_q   <= 1'b0;
            port_q  <= 1'b0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            isq_q   <= isq_d;
            port_q  <= port_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    assign req_ready_o  = (grant_vld && !rst_i) ? (grant_port ? 2'b10 : 2'b01) : 2'b00;
    assign resp_valid_o = (state_q == S_RESP);
    assign resp_data_o  = data_q;
    assign resp_port_o  = port_q;
    assign resp_err_o   = err_q;
    assign div_start_o  = (state_q == S_BUSY);
    assign div_a_o      = a_q;
    assign div_b_o      = b_q;
    assign div_is_q_o   = isq_q;
    assign busy_o       = (state_q != S_IDLE);

endmodule

// File: tb/tb_div_sched.sv
// Directed bench for div_sched with a combinational stub divider whose done pulse is driven by the sequence.
module tb_div_sched;

    logic        clk = 1'b0;
    logic        rst_i;
    logic [1:0]  req_valid_i;
    logic [1:0]  req_ready_o;
    logic [63:0] req_a_i, req_b_i;
    logic [1:0]  req_is_q_i;
    logic        flush_i;
    logic        resp_valid_o, resp_ready_i;
    logic [31:0] resp_data_o;
    logic        resp_port_o, resp_err_o;
    logic        div_start_o;
    logic [31:0] div_a_o, div_b_o;
    logic        div_is_q_o;
    logic [31:0] div_result_i;
    logic        div_done_i;
    logic        busy_o;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    // Stub divider: RISC-V style divide-by-zero results.
    assign div_result_i = (div_b_o == 32'd0) ? (div_is_q_o ? 32'hFFFF_FFFF : div_a_o)
                        : (div_is_q_o ? div_a_o / div_b_o : div_a_o % div_b_o);

    div_sched dut (
        .clk_i(clk), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_a_i(req_a_i), .req_b_i(req_b_i), .req_is_q_i(req_is_q_i),
        .flush_i(flush_i),
        .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
        .resp_data_o(resp_data_o), .resp_port_o(resp_port_o), .resp_err_o(resp_err_o),
        .div_start_o(div_start_o), .div_a_o(div_a_o), .div_b_o(div_b_o),
        .div_is_q_o(div_is_q_o), .div_result_i(div_result_i), .div_done_i(div_done_i),
        .busy_o(busy_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int p, input logic [31:0] a, input logic [31:0] b, input logic isq);
        req_a_i    = (p == 1) ? {a, 32'hDEAD_0000} : {32'hDEAD_0000, a};
        req_b_i    = (p == 1) ? {b, 32'h0000_0003} : {32'h0000_0003, b};
        req_is_q_i = (p == 1) ? {isq, ~isq} : {~isq, isq};
    endtask

    task automatic do_op(input string tag, input int p, input logic [31:0] a, input logic [31:0] b,
                         input logic isq, input int lat, input logic [31:0] expd);
        @(negedge clk);
        set_req(p, a, b, isq);
        req_valid_i = 2'b01 << p;
        #1 chk({tag, "_ready"}, {30'd0, req_ready_o}, 32'd1 << p);
        @(negedge clk);
        req_valid_i = 2'b00;
        #1 chk({tag, "_start"}, {31'd0, div_start_o}, 32'd1);
        chk({tag, "_diva"}, div_a_o, a);
        repeat (lat) @(negedge clk);
        div_done_i = 1'b1;
        @(negedge clk);
        div_done_i = 1'b0;
        #1 chk({tag, "_rvalid"}, {31'd0, resp_valid_o}, 32'd1);
        chk({tag, "_data"}, resp_data_o, expd);
        chk({tag, "_port"}, {31'd0, resp_port_o}, p);
        chk({tag, "_err"}, {31'd0, resp_err_o}, 32'd0);
        chk({tag, "_startlow"}, {31'd0, div_start_o}, 32'd0);
        resp_ready_i = 1'b1;
        @(negedge clk);
        resp_ready_i = 1'b0;
        #1 chk({tag, "_idle"}, {31'd0, busy_o}, 32'd0);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_i = 1'b1;
        @(negedge clk);
        rst_i = 1'b0;
    endtask

    initial begin
        rst_i = 1'b1; req_valid_i = 2'b00; req_a_i = '0; req_b_i = '0; req_is_q_i = 2'b00;
        flush_i = 1'b0; resp_ready_i = 1'b0; div_done_i = 1'b0;
        @(negedge clk);
        #1 chk("rst_busy", {31'd0, busy_o}, 32'd0);
        chk("rst_start", {31'd0, div_start_o}, 32'd0);
        chk("rst_rvalid", {31'd0, resp_valid_o}, 32'd0);
        @(negedge clk);
        rst_i = 1'b0;

        do_op("q100_7", 0, 32'd100, 32'd7, 1'b1, 3, 32'd14);
        do_op("r100_7", 1, 32'd100, 32'd7, 1'b0, 1, 32'd2);
        do_op("q5_0", 0, 32'd5, 32'd0, 1'b1, 2, 32'hFFFF_FFFF);
        do_op("r5_0", 0, 32'd5, 32'd0, 1'b0, 0, 32'd5);

        // Done pulse while idle must not create a response.
        @(negedge clk);
        div_done_i = 1'b1;
        @(negedge clk);
        div_done_i = 1'b0;
        #1 chk("idle_done_rvalid", {31'd0, resp_valid_o}, 32'd0);
        chk("idle_done_busy", {31'd0, busy_o}, 32'd0);

        // Flush in IDLE blocks the grant.
        set_req(0, 32'd9, 32'd3, 1'b1);
        req_valid_i = 2'b01; flush_i = 1'b1;
        #1 chk("flush_idle_ready", {30'd0, req_ready_o}, 32'd0);
        @(negedge clk);
        flush_i = 1'b0; req_valid_i = 2'b00;
        #1 chk("flush_idle_busy", {31'd0, busy_o}, 32'd0);

        // Round robin from reset with both ports held valid.
        pulse_reset();
        set_req(0, 32'd20, 32'd4, 1'b1);
        req_valid_i = 2'b11;
        for (int k = 0; k < 3; k++) begin
            #1 chk($sformatf("rr_grant%0d", k), {30'd0, req_ready_o}, (k == 1) ? 32'd2 : 32'd1);
            @(negedge clk);
            #1 chk($sformatf("rr_busy_ready%0d", k), {30'd0, req_ready_o}, 32'd0);
            chk($sformatf("rr_port_sel%0d", k), div_a_o, (k == 1) ? 32'hDEAD_0000 : 32'd20);
            div_done_i = 1'b1;
            @(negedge clk);
            div_done_i = 1'b0;
            #1 chk($sformatf("rr_resp_ready%0d", k), {30'd0, req_ready_o}, 32'd0);
            chk($sformatf("rr_rport%0d", k), {31'd0, resp_port_o}, (k == 1) ? 32'd1 : 32'd0);
            resp_ready_i = 1'b1;
            @(negedge clk);
            resp_ready_i = 1'b0;
        end
        req_valid_i = 2'b00;

        // Flush in 10th BUSY cycle together with done.
        set_req(1, 32'd50, 32'd5, 1'b1);
        req_valid_i = 2'b10;
        @(negedge clk);
        req_valid_i = 2'b00;
        repeat (9) @(negedge clk);
        #1 chk("fl_still_busy", {31'd0, div_start_o}, 32'd1);
        flush_i = 1'b1; div_done_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0; div_done_i = 1'b0;
        #1 chk("fl_rvalid", {31'd0, resp_valid_o}, 32'd0);
        chk("fl_start", {31'd0, div_start_o}, 32'd0);
        chk("fl_busy", {31'd0, busy_o}, 32'd0);
        do_op("after_fl", 1, 32'd50, 32'd5, 1'b1, 2, 32'd10);

        // Response back-pressure for 10 cycles, then flush-free release.
        set_req(0, 32'd77, 32'd10, 1'b0);
        req_valid_i = 2'b01;
        @(negedge clk);
        div_done_i = 1'b1;
        @(negedge clk);
        div_done_i = 1'b0;
        for (int k = 0; k < 10; k++) begin
            #1;
            if (!(resp_valid_o === 1'b1 && resp_data_o === 32'd7 && req_ready_o === 2'b00 && busy_o === 1'b1)) begin
                chk($sformatf("bp_cycle%0d", k), {resp_valid_o, busy_o, req_ready_o, resp_data_o[27:0]},
                    {1'b1, 1'b1, 2'b00, 28'd7});
            end
            @(negedge clk);
        end
        #1 chk("bp_data", resp_data_o, 32'd7);
        chk("bp_ready", {30'd0, req_ready_o}, 32'd0);
        req_valid_i = 2'b00; resp_ready_i = 1'b1;
        @(negedge clk);
        resp_ready_i = 1'b0;
        #1 chk("bp_idle", {31'd0, busy_o}, 32'd0);

        // Flush in RESP drops the response.
        set_req(0, 32'd8, 32'd2, 1'b1);
        req_valid_i = 2'b01;
        @(negedge clk);
        req_valid_i = 2'b00; div_done_i = 1'b1;
        @(negedge clk);
        div_done_i = 1'b0;
        #1 chk("flresp_valid", {31'd0, resp_valid_o}, 32'd1);
        flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
        #1 chk("flresp_drop", {31'd0, resp_valid_o}, 32'd0);

        // Timeout after 64 BUSY cycles with no done.
        set_req(1, 32'd1, 32'd1, 1'b1);
        req_valid_i = 2'b10;
        @(negedge clk);
        req_valid_i = 2'b00;
        repeat (63) @(negedge clk);
        #1 chk("to_not_yet", {31'd0, resp_valid_o}, 32'd0);
        chk("to_start64", {31'd0, div_start_o}, 32'd1);
        @(negedge clk);
        #1 chk("to_rvalid", {31'd0, resp_valid_o}, 32'd1);
        chk("to_err", {31'd0, resp_err_o}, 32'd1);
        chk("to_data", resp_data_o, 32'd0);
        chk("to_port", {31'd0, resp_port_o}, 32'd1);
        resp_ready_i = 1'b1;
        @(negedge clk);
        resp_ready_i = 1'b0;

        // Reset mid-BUSY after a port-0 grant (rr left at 1).
        set_req(0, 32'd33, 32'd3, 1'b1);
        req_valid_i = 2'b01;
        @(negedge clk);
        req_valid_i = 2'b11;
        repeat (3) @(negedge clk);
        rst_i = 1'b1;
        #1 chk("mr_start", {31'd0, div_start_o}, 32'd0);
        chk("mr_busy", {31'd0, busy_o}, 32'd0);
        chk("mr_ready", {30'd0, req_ready_o}, 32'd0);
        chk("mr_diva", div_a_o, 32'd0);
        chk("mr_rvalid", {31'd0, resp_valid_o}, 32'd0);
        @(negedge clk);
        rst_i = 1'b0;
        #1 chk("mr_first_grant", {30'd0, req_ready_o}, 32'd1);
        @(negedge clk);
        req_valid_i = 2'b00;
        #1 chk("mr_start_after", {31'd0, div_start_o}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/div_sched.md
DIV_SCHED -- requirements
Module: div_sched

Interface
REQ-001 Parameter XLEN, default 32, operand/result width.
REQ-002 Parameter TIMEOUT, default 64, max BUSY cycles before abort.
REQ-003 clk_i  input  1  single clock; all state on rising edge.
REQ-004 rst_i  input  1  reset, asynchronous, active-high.
REQ-005 req_valid_i  input  2  per-port request valid (port 0 = bit 0).
REQ-006 req_ready_o  output  2  per-port accept; at most one bit set per cycle.
REQ-007 req_a_i  input  2*XLEN  dividends, port p at [p*XLEN +: XLEN].
REQ-008 req_b_i  input  2*XLEN  divisors, same packing.
REQ-009 req_is_q_i  input  2  1 = quotient, 0 = remainder.
REQ-010 flush_i  input  1  kill in-flight or pending operation.
REQ-011 resp_valid_o  output  1  response valid.
REQ-012 resp_ready_i  input  1  consumer accepts response.
REQ-013 resp_data_o  output  XLEN  result.
REQ-014 resp_port_o  output  1  originating port.
REQ-015 resp_err_o  output  1  1 = timeout abort; resp_data_o = 0.
REQ-016 div_start_o  output  1  divider start, level, held for whole operation.
REQ-017 div_a_o, div_b_o  output  XLEN each  divider operands, stable while div_start_o = 1.
REQ-018 div_is_q_o  output  1  divider quotient/remainder select.
REQ-019 div_result_i  input  XLEN  divider result, valid with div_done_i.
REQ-020 div_done_i  input  1  divider one-cycle completion pulse.
REQ-021 busy_o  output  1  state != IDLE.

Function
REQ-022 FSM states IDLE, BUSY, RESP; div_start_o SHALL be a pure decode of state == BUSY.
REQ-023 IDLE: no flush_i and any req_valid_i -> grant one port combinationally, assert its req_ready_o, latch a/b/is_q/port; next BUSY.
REQ-024 Round-robin: 1-bit pointer rr; both valid -> grant port rr; after any grant rr = ~granted port; reset rr = 0.
REQ-025 BUSY: timeout counter increments each cycle; div_done_i -> capture div_result_i, err = 0, next RESP.
REQ-026 BUSY with counter == TIMEOUT-1 and no div_done_i -> data 0, err = 1, next RESP.
REQ-027 RESP: resp_valid_o = 1, data/port/err stable; resp_ready_i -> next IDLE; req_ready_o = 0.
REQ-028 Latency: req handshake at edge T -> div_start_o high from T+1; response visible the cycle after div_done_i.
REQ-029 Leaving BUSY always passes through RESP or IDLE, so div_start_o is low at least one edge between operations (aborts/rearms the divider); a one-cycle divider re-arm at the exit edge is permitted and SHALL be ignored.
REQ-030 flush_i priority over everything: IDLE -> no grant that cycle; BUSY -> next IDLE, result discarded even if div_done_i same cycle; RESP -> response dropped, next IDLE.
REQ-031 div_done_i outside BUSY SHALL be ignored.
REQ-032 Divide by zero and zero dividend are not special-cased; divider result is forwarded unchanged.
REQ-033 Operand registers hold value until next grant; no combinational path req_*_i -> div_*_o.

Reset
REQ-034 rst_i asserted (any time, incl. mid-BUSY): state IDLE, rr = 0, counter = 0, all outputs 0 immediately; div_start_o drop aborts the divider.
REQ-035 After rst_i release first request accepted in the first IDLE cycle with valid.

Verification
REQ-036 Port0 a=100 b=7 is_q=1 -> req_ready_o[0] in accept cycle, div_start_o high until done, resp 14, port 0, err 0.
REQ-037 Port1 a=100 b=7 is_q=0 -> resp 2, port 1; port0 a=5 b=0 is_q=1 -> 0xFFFFFFFF, is_q=0 -> 5.
REQ-038 Both ports held valid from reset, three ops -> grant order 0,1,0; never both ready bits.
REQ-039 flush_i in 10th BUSY cycle coincident with div_done_i -> no resp_valid_o, div_start_o low next cycle, next request accepted normally.
REQ-040 resp_ready_i low 10 cycles in RESP -> outputs stable, req_ready_o = 0, busy_o = 1; release -> IDLE next cycle.
REQ-041 Stub divider never done -> after 64 BUSY cycles resp_valid_o, err 1, data 0; rst_i mid-BUSY -> all outputs 0 same cycle.
